// File: rtl/rsp_tx_pkg.sv
// Shared types and constants for the response transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, byte count per response, data bits per byte,
// datapath result width. When RSP_TX_PARITY_EN is defined the enum gains
// a PARITY state between DATA and STOP.
package rsp_tx_pkg;

    localparam int NUM_BYTES = 2;   // bytes per response frame
    localparam int DATA_BITS = 8;   // data bits per UART character
    localparam int DST_W     = 14;  // width of the datapath result

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef RSP_TX_PARITY_EN
        PARITY,
`endif
        STOP,
        GAP,
        DONE
    } state_t;

endpackage

// File: rtl/rsp_baud_gen.sv
// Bit-period timer: counts BAUD_DIV clocks per UART bit while enabled.
// Latency: bit_tick asserts in the last clock of each bit period.
// Backpressure: none; held at zero whenever en is low.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset
//   en       - count enable from the transmit FSM
//   bit_tick - high in the final clock of every bit period
module rsp_baud_gen #(
    parameter int BAUD_DIV = 2604
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bit_tick
);

    localparam int CW = $clog2(BAUD_DIV);

    logic [CW-1:0] cnt;
    logic          cnt_last;

    assign cnt_last = (cnt == CW'(BAUD_DIV - 1));
    assign bit_tick = en && cnt_last;

    // Clearing while disabled guarantees every frame starts on a full bit.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else if (cnt_last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rsp_tx.sv
// Serialises a 14-bit result as two 8N1 UART bytes: {2'b00,dst[13:8]} then dst[7:0].
// Latency: TX drops for the first start bit one clock after the accepting snd_rsp edge.
// Backpressure: requests arriving while busy (or in the DONE cycle) are dropped, not queued.
//
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset; aborts any frame in flight
//   snd_rsp - send request; only a rising edge while idle is accepted
//   dst     - result to transmit, captured on acceptance
//   TX      - UART line, idles high
//   tx_busy - high from the cycle after acceptance to the end of the last stop bit
//   tx_done - single-cycle pulse after the final stop bit
// Build option: RSP_TX_PARITY_EN adds an even-parity bit before each stop bit.
module rsp_tx
    import rsp_tx_pkg::*;
#(
    parameter int BAUD_DIV = 2604,
    parameter int GAP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             snd_rsp,
    input  logic [DST_W-1:0] dst,
    output logic             TX,
    output logic             tx_busy,
    output logic             tx_done
);

    localparam int GAP_W = 4;

    state_t                 state;
    state_t                 state_nxt;
    logic                   snd_q;
    logic                   accept;
    logic [DATA_BITS-1:0]   shreg;
    logic [DATA_BITS-1:0]   byte1;
    logic [DATA_BITS-1:0]   byte0_w;
    logic                   byte_idx;
    logic [2:0]             bit_cnt;
    logic [GAP_W-1:0]       gap_cnt;
    logic                   bit_tick;
    logic                   baud_en;
    logic                   last_bit;
    logic                   last_byte;
    logic                   gap_last;
    logic                   tx_bit;
`ifdef RSP_TX_PARITY_EN
    logic                   par;
`endif

    assign byte0_w   = DATA_BITS'(dst[DST_W-1:DATA_BITS]);
    assign accept    = snd_rsp && !snd_q && (state == IDLE);
    assign last_bit  = (bit_cnt == 3'(DATA_BITS - 1));
    assign last_byte = (byte_idx == 1'(NUM_BYTES - 1));
    assign gap_last  = (gap_cnt == GAP_W'(GAP_BITS - 1));

    // The bit timer runs only while a line bit is being driven.
    assign baud_en = (state != IDLE) && (state != DONE);

    rsp_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .en       (baud_en),
        .bit_tick (bit_tick)
    );

    always_comb begin
        state_nxt = state;
        tx_bit    = 1'b1;
        case (state)
            IDLE: begin
                if (accept) state_nxt = START;
            end
            START: begin
                tx_bit = 1'b0;
                if (bit_tick) state_nxt = DATA;
            end
            DATA: begin
                tx_bit = shreg[0];
                if (bit_tick && last_bit) begin
`ifdef RSP_TX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef RSP_TX_PARITY_EN
            PARITY: begin
                tx_bit = par;
                if (bit_tick) state_nxt = STOP;
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    if (last_byte)        state_nxt = DONE;
                    else if (GAP_BITS > 0) state_nxt = GAP;
                    else                   state_nxt = START;
                end
            end
            GAP: begin
                if (bit_tick && gap_last) state_nxt = START;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            snd_q    <= 1'b0;
            shreg    <= '0;
            byte1    <= '0;
            byte_idx <= 1'b0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
`ifdef RSP_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            // Tracks the line in every state so an edge right after DONE is seen.
            snd_q <= snd_rsp;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg    <= byte0_w;
                        byte1    <= dst[DATA_BITS-1:0];
                        byte_idx <= 1'b0;
                        bit_cnt  <= '0;
                        gap_cnt  <= '0;
`ifdef RSP_TX_PARITY_EN
                        par      <= ^byte0_w;
`endif
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;  // 3 bits: wraps 7 -> 0
                    end
                end
                STOP: begin
                    // Second byte is loaded at the end of the first stop bit,
                    // ready for either the gap or an immediate start bit.
                    if (bit_tick && !last_byte) begin
                        shreg    <= byte1;
                        byte_idx <= byte_idx + 1'b1;
`ifdef RSP_TX_PARITY_EN
                        par      <= ^byte1;
`endif
                    end
                end
                GAP: begin
                    if (bit_tick) gap_cnt <= gap_last ? '0 : gap_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign TX      = tx_bit;
    assign tx_busy = baud_en;
    assign tx_done = (state == DONE);

endmodule

// File: tb/tb_rsp_tx.sv
// Directed bench for rsp_tx: table of frames plus reset/edge corner sequences.
// Two instances: BAUD_DIV=4 with GAP_BITS=0 and with GAP_BITS=2.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_rsp_tx;

    localparam int BD = 4;
`ifdef RSP_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    typedef struct {
        logic [13:0] d;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic        p0;
        logic        p1;
        int          sel;   // 0: GAP_BITS=0 instance, 1: GAP_BITS=2 instance
        int          gap;
        int          hold;  // clocks snd_rsp stays high
        int          inj;   // frame clock at which a second request is injected (-1 none)
        int          post;  // 0 none, 1 pulse during DONE, 2 pulse in first IDLE
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        snd_rsp;
    logic [13:0] dst;
    logic        snd0, snd1;
    logic        tx0, tx1, busy0, busy1, done0, done1;
    logic        tx_m, busy_m, done_m;
    int          cur_sel = 0;
    int          total = 0;
    int          bad = 0;
    vec_t        vecs[7];

    always #5 clk = ~clk;

    assign snd0 = snd_rsp && (cur_sel == 0);
    assign snd1 = snd_rsp && (cur_sel == 1);

    always_comb begin
        tx_m   = tx0;
        busy_m = busy0;
        done_m = done0;
        if (cur_sel == 1) begin
            tx_m   = tx1;
            busy_m = busy1;
            done_m = done1;
        end
    end

    rsp_tx #(.BAUD_DIV(BD), .GAP_BITS(0)) u_dut0 (
        .clk(clk), .rst(rst), .snd_rsp(snd0), .dst(dst),
        .TX(tx0), .tx_busy(busy0), .tx_done(done0)
    );

    rsp_tx #(.BAUD_DIV(BD), .GAP_BITS(2)) u_dut1 (
        .clk(clk), .rst(rst), .snd_rsp(snd1), .dst(dst),
        .TX(tx1), .tx_busy(busy1), .tx_done(done1)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v, input string nm);
        logic exp_bits[64];
        int   n;
        int   k;
        logic slot_bad;
        logic got;
        logic ctl_bad;
        logic seen;
        cur_sel = v.sel;
        n = 0;
        exp_bits[n] = 1'b0; n = n + 1;
        for (int i = 0; i < 8; i++) begin exp_bits[n] = v.b0[i]; n = n + 1; end
        if (PB == 1) begin exp_bits[n] = v.p0; n = n + 1; end
        exp_bits[n] = 1'b1; n = n + 1;
        for (int g = 0; g < v.gap; g++) begin exp_bits[n] = 1'b1; n = n + 1; end
        exp_bits[n] = 1'b0; n = n + 1;
        for (int i = 0; i < 8; i++) begin exp_bits[n] = v.b1[i]; n = n + 1; end
        if (PB == 1) begin exp_bits[n] = v.p1; n = n + 1; end
        exp_bits[n] = 1'b1; n = n + 1;

        chk({nm, " idle TX"}, 16'(tx_m), 16'h1);
        chk({nm, " idle busy"}, 16'(busy_m), 16'h0);
        snd_rsp = 1'b1;
        dst     = v.d;
        @(negedge clk);
        ctl_bad = 1'b0;
        for (int s = 0; s < n; s++) begin
            slot_bad = 1'b0;
            got      = exp_bits[s];
            for (int c = 0; c < BD; c++) begin
                k = s * BD + c;
                if (tx_m !== exp_bits[s]) begin slot_bad = 1'b1; got = tx_m; end
                if (busy_m !== 1'b1 || done_m !== 1'b0) ctl_bad = 1'b1;
                if (k == v.hold - 1) begin snd_rsp = 1'b0; dst = ~v.d; end
                if (v.inj >= 0) begin
                    if (k == v.inj) begin snd_rsp = 1'b1; dst = 14'h0001; end
                    else if (k == v.inj + 1) snd_rsp = 1'b0;
                end
                @(negedge clk);
            end
            chk($sformatf("%s bit%0d", nm, s), 16'(got), 16'(exp_bits[s]));
        end
        chk({nm, " busy/done during frame"}, 16'(ctl_bad), 16'h0);
        // Frame clock n*BD: the DONE cycle.
        chk({nm, " done pulse"}, 16'(done_m), 16'h1);
        chk({nm, " busy in DONE"}, 16'(busy_m), 16'h0);
        chk({nm, " TX in DONE"}, 16'(tx_m), 16'h1);
        if (v.post == 1) begin
            snd_rsp = 1'b1;
            dst     = 14'h0FF0;
            @(negedge clk);
            snd_rsp = 1'b0;
            chk({nm, " DONE edge busy"}, 16'(busy_m), 16'h0);
            chk({nm, " done single"}, 16'(done_m), 16'h0);
            @(negedge clk);
            chk({nm, " DONE edge ignored busy"}, 16'(busy_m), 16'h0);
            chk({nm, " DONE edge ignored TX"}, 16'(tx_m), 16'h1);
        end else if (v.post == 2) begin
            @(negedge clk);
            chk({nm, " done single"}, 16'(done_m), 16'h0);
            chk({nm, " idle after done"}, 16'(busy_m), 16'h0);
            snd_rsp = 1'b1;
            dst     = 14'h2A5C;
            @(negedge clk);
            snd_rsp = 1'b0;
            chk({nm, " IDLE edge TX"}, 16'(tx_m), 16'h0);
            chk({nm, " IDLE edge busy"}, 16'(busy_m), 16'h1);
            seen = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (done_m === 1'b1) begin seen = 1'b1; break; end
            end
            chk({nm, " follow-on frame done"}, 16'(seen), 16'h1);
            @(negedge clk);
        end else begin
            @(negedge clk);
            chk({nm, " done single"}, 16'(done_m), 16'h0);
            chk({nm, " TX idle after"}, 16'(tx_m), 16'h1);
            chk({nm, " busy idle after"}, 16'(busy_m), 16'h0);
        end
    endtask

    initial begin
        logic seen;
        logic tx_hi;
        vecs[0] = '{14'h2A5C, 8'h2A, 8'h5C, 1'b1, 1'b0, 0, 0, 1, -1, 0};
        vecs[1] = '{14'h3FFF, 8'h3F, 8'hFF, 1'b0, 1'b0, 0, 0, 2, -1, 0};
        vecs[2] = '{14'h1234, 8'h12, 8'h34, 1'b0, 1'b1, 0, 0, 1, 30, 0};
        vecs[3] = '{14'h0155, 8'h01, 8'h55, 1'b1, 1'b0, 1, 2, 1, -1, 0};
        vecs[4] = '{14'h0007, 8'h00, 8'h07, 1'b0, 1'b1, 0, 0, 1, -1, 0};
        vecs[5] = '{14'h0001, 8'h00, 8'h01, 1'b0, 1'b1, 0, 0, 1, -1, 1};
        vecs[6] = '{14'h3C00, 8'h3C, 8'h00, 1'b0, 1'b0, 0, 0, 1, -1, 2};

        rst     = 1'b1;
        snd_rsp = 1'b0;
        dst     = '0;
        repeat (3) @(negedge clk);
        chk("reset TX0", 16'(tx0), 16'h1);
        chk("reset busy0", 16'(busy0), 16'h0);
        chk("reset done0", 16'(done0), 16'h0);
        chk("reset TX1", 16'(tx1), 16'h1);
        chk("reset busy1", 16'(busy1), 16'h0);
        chk("reset done1", 16'(done1), 16'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i], $sformatf("vec%0d", i));
            repeat (2) @(negedge clk);
        end

        // Abort mid-frame with reset.
        cur_sel = 0;
        snd_rsp = 1'b1;
        dst     = 14'h2A5C;
        @(negedge clk);
        snd_rsp = 1'b0;
        repeat (24) @(negedge clk);
        chk("pre-abort busy", 16'(busy_m), 16'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort TX", 16'(tx_m), 16'h1);
        chk("abort busy", 16'(busy_m), 16'h0);
        chk("abort done", 16'(done_m), 16'h0);
        seen  = 1'b0;
        tx_hi = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done_m !== 1'b0) seen = 1'b1;
            if (tx_m !== 1'b1) tx_hi = 1'b0;
        end
        chk("no done after abort", 16'(seen), 16'h0);
        chk("TX idle after abort", 16'(tx_hi), 16'h1);
        run_frame(vecs[0], "post-abort");
        repeat (2) @(negedge clk);

        // snd_rsp held high through reset release must start a frame.
        rst     = 1'b1;
        snd_rsp = 1'b1;
        dst     = 14'h2A5C;
        @(negedge clk);
        rst = 1'b0;
        run_frame(vecs[0], "held-thru-reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
